// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared state encoding and default geometry for the register snapshot dumper.
package reg_dump_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2} dump_state_t;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_REGS = 13;
  localparam int DEF_IDX_W = 5;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_END_COUNT = 25;
endpackage

// File: rtl/dump_cycle_counter.sv
// dump_cycle_counter: cycle counter that wraps (periodic) or saturates (one-shot) and raises auto fire.
module dump_cycle_counter
  import reg_dump_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int END_COUNT = DEF_END_COUNT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             mode_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             fired_o,
  output logic             auto_fire_o
);
  localparam logic [CNT_W-1:0] TOP = CNT_W'(END_COUNT - 1);
  logic at_top;
  assign at_top = cnt_o == TOP;
  // one-shot mode only auto fires once; periodic fires on every wrap
  assign auto_fire_o = enable_i & at_top & (mode_i | ~fired_o);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      cnt_o <= '0;
      fired_o <= 1'b0;
    end else if (enable_i) begin
      cnt_o <= at_top ? (mode_i ? '0 : TOP) : cnt_o + 1'b1;
      if (auto_fire_o) fired_o <= 1'b1;
    end
endmodule

// File: rtl/reg_snapshot_dumper.sv
// reg_snapshot_dumper: snapshots the register file on fire and streams it as (index, data) beats.
module reg_snapshot_dumper
  import reg_dump_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int IDX_W = DEF_IDX_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int END_COUNT = DEF_END_COUNT
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       mode_i,
  input  logic                       trig_i,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat_i,
  input  logic                       dump_ready_i,
  output logic                       dump_valid_o,
  output logic [IDX_W-1:0]           dump_idx_o,
  output logic [DATA_W-1:0]          dump_data_o,
  output logic                       dump_last_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       overrun_o,
  output logic [CNT_W-1:0]           cycle_cnt_o
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  dump_state_t state;
  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic fired, auto_fire, fire, hs, fin, capture, auto_dump;
  dump_cycle_counter #(.CNT_W(CNT_W), .END_COUNT(END_COUNT)) u_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .enable_i(enable_i),
    .mode_i(mode_i),
    .cnt_o(cycle_cnt_o),
    .fired_o(fired),
    .auto_fire_o(auto_fire)
  );
  assign fire = auto_fire | (enable_i & trig_i);
  assign hs = dump_valid_o & dump_ready_i;
  assign fin = hs & dump_last_o;
  // a fire landing on the final handshake chains straight into the next dump
  assign capture = fire & ((state != STREAM) | fin);
  assign dump_data_o = dump_valid_o ? shadow[dump_idx_o] : '0;
  always_ff @(posedge clk_i)
    if (capture)
      for (int k = 0; k < NUM_REGS; k++) shadow[k] <= regs_flat_i[k*DATA_W +: DATA_W];
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state <= IDLE;
      dump_valid_o <= 1'b0;
      dump_idx_o <= '0;
      dump_last_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      overrun_o <= 1'b0;
      auto_dump <= 1'b0;
    end else begin
      if (capture) begin
        state <= STREAM;
        dump_valid_o <= 1'b1;
        busy_o <= 1'b1;
        dump_idx_o <= '0;
        dump_last_o <= LAST_IDX == '0;
        auto_dump <= auto_fire & ~mode_i;
      end else if (fin) begin
        state <= (~mode_i & fired) ? DONE : IDLE;
        dump_valid_o <= 1'b0;
        busy_o <= 1'b0;
        dump_idx_o <= '0;
        dump_last_o <= 1'b0;
      end else if (hs) begin
        dump_idx_o <= dump_idx_o + 1'b1;
        dump_last_o <= (dump_idx_o + 1'b1) == LAST_IDX;
      end
      if (fin & auto_dump) done_o <= 1'b1;
      if (fire & (state == STREAM) & ~fin) overrun_o <= 1'b1;
    end
endmodule

// File: tb/tb_reg_snapshot_dumper.sv
// tb_reg_snapshot_dumper: scoreboard bench; stimulus pushes expected beats, a monitor pops and compares.
module tb_reg_snapshot_dumper;
  import reg_dump_pkg::*;
  localparam int DW = DEF_DATA_W;
  localparam int NR = DEF_NUM_REGS;
  localparam int IW = DEF_IDX_W;
  localparam int CW = DEF_CNT_W;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, mode = 1'b0, trig = 1'b0, ready = 1'b1;
  logic [DW-1:0] regs [NR];
  logic [NR*DW-1:0] regs_flat;
  logic valid, last, busy, done, overrun;
  logic [IW-1:0] idx;
  logic [DW-1:0] data;
  logic [CW-1:0] cnt;
  int checks = 0, errors = 0;
  int rmode = 0, rphase = 0;
  typedef struct {logic [IW-1:0] idx; logic [DW-1:0] data; logic last;} beat_t;
  beat_t exp_q[$];
  for (genvar g = 0; g < NR; g++) assign regs_flat[g*DW +: DW] = regs[g];
  reg_snapshot_dumper dut (
    .clk_i(clk), .rst_i(rst_n), .enable_i(enable), .mode_i(mode), .trig_i(trig),
    .regs_flat_i(regs_flat), .dump_ready_i(ready), .dump_valid_o(valid), .dump_idx_o(idx),
    .dump_data_o(data), .dump_last_o(last), .busy_o(busy), .done_o(done),
    .overrun_o(overrun), .cycle_cnt_o(cnt)
  );
  initial forever #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // ready: 0 = always 1, 1 = pattern 1,0,0 repeating, 2 = held low
  initial forever begin
    @(posedge clk);
    #1;
    if (rmode == 1) begin
      ready = (rphase % 3) == 0;
      rphase++;
    end else ready = (rmode == 0);
  end
  initial begin
    logic pstall = 1'b0;
    logic [IW-1:0] pidx = '0;
    logic [DW-1:0] pdata = '0;
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pstall = 1'b0;
        continue;
      end
      if (pstall) begin
        chk("stall_valid", 64'(valid), 64'd1);
        chk("stall_idx", 64'(idx), 64'(pidx));
        chk("stall_data", 64'(data), 64'(pdata));
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got idx %0d data %0d expected no beat", idx, data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_idx", 64'(idx), 64'(e.idx));
          chk("beat_data", 64'(data), 64'(e.data));
          chk("beat_last", 64'(last), 64'(e.last));
        end
      end
      pstall = valid && !ready;
      pidx = idx;
      pdata = data;
    end
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_regs(int mul, int add);
    for (int k = 0; k < NR; k++) regs[k] = DW'(k * mul + add);
  endtask
  task automatic push_dump();
    for (int k = 0; k < NR; k++) exp_q.push_back('{IW'(k), regs[k], k == NR - 1});
  endtask
  task automatic wait_valid(int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < budget);
    chk("wait_valid", 64'(valid), 64'd1);
  endtask
  task automatic wait_idle(int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    chk("wait_idle", 64'(busy), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask
  task automatic chk_reset_state(string tag);
    chk({tag, "_valid"}, 64'(valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_overrun"}, 64'(overrun), 64'd0);
    chk({tag, "_cnt"}, 64'(cnt), 64'd0);
    chk({tag, "_idx"}, 64'(idx), 64'd0);
    chk({tag, "_last"}, 64'(last), 64'd0);
  endtask
  initial begin
    int n;
    set_regs(3, 0);
    #1;
    chk_reset_state("reset");
    #2;
    rst_n = 1'b1;
    enable = 1'b1;
    // one-shot auto dump at count 24 with snapshot isolation on reg 5
    push_dump();
    repeat (24) @(posedge clk);
    @(negedge clk);
    chk("pre_fire_valid", 64'(valid), 64'd0);
    chk("pre_fire_cnt", 64'(cnt), 64'd24);
    @(negedge clk);
    chk("first_valid", 64'(valid), 64'd1);
    chk("first_busy", 64'(busy), 64'd1);
    chk("first_cnt", 64'(cnt), 64'd24);
    tick(2);
    regs[5] = 999;
    wait_idle(40);
    regs[5] = 15;
    chk("oneshot_done", 64'(done), 64'd1);
    tick(5);
    chk("sat_cnt", 64'(cnt), 64'd24);
    chk("sat_valid", 64'(valid), 64'd0);
    // manual trigger from DONE under backpressure
    set_regs(5, 1);
    rmode = 1;
    trig = 1'b1;
    push_dump();
    tick(1);
    trig = 1'b0;
    wait_idle(80);
    rmode = 0;
    chk("manual_done_kept", 64'(done), 64'd1);
    chk("manual_overrun", 64'(overrun), 64'd0);
    // trigger on the final handshake chains a second dump with no gap
    set_regs(3, 0);
    tick(2);
    trig = 1'b1;
    push_dump();
    tick(1);
    trig = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(valid && last) && n < 40);
    chk("reach_last", 64'(valid && last), 64'd1);
    set_regs(1, 100);
    trig = 1'b1;
    push_dump();
    @(posedge clk);
    #1;
    trig = 1'b0;
    @(negedge clk);
    chk("b2b_valid", 64'(valid), 64'd1);
    chk("b2b_idx", 64'(idx), 64'd0);
    chk("b2b_overrun", 64'(overrun), 64'd0);
    wait_idle(40);
    chk("b2b_overrun_end", 64'(overrun), 64'd0);
    // trigger mid-stream is ignored but flags overrun
    set_regs(2, 7);
    trig = 1'b1;
    push_dump();
    tick(1);
    trig = 1'b0;
    tick(3);
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    wait_idle(40);
    chk("midstream_overrun", 64'(overrun), 64'd1);
    // periodic mode
    rst_n = 1'b0;
    #1;
    chk_reset_state("reset2");
    rst_n = 1'b1;
    mode = 1'b1;
    set_regs(3, 0);
    for (int d = 0; d < 2; d++) begin
      push_dump();
      wait_valid(40);
      chk("periodic_start_cnt", 64'(cnt), 64'd0);
      chk("periodic_start_idx", 64'(idx), 64'd0);
      wait_idle(30);
      chk("periodic_overrun", 64'(overrun), 64'd0);
    end
    push_dump();
    wait_valid(40);
    chk("stall_start_cnt", 64'(cnt), 64'd0);
    rmode = 2;
    tick(30);
    chk("stall_overrun", 64'(overrun), 64'd1);
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_hold_idx", 64'(idx), 64'd1);
    enable = 1'b0;
    rmode = 0;
    wait_idle(40);
    chk("held_cnt", 64'(cnt), 64'd5);
    // manual trigger at cycle 5, then reset mid-stream at beat 7
    rst_n = 1'b0;
    #1;
    chk_reset_state("reset3");
    rst_n = 1'b1;
    mode = 1'b0;
    enable = 1'b1;
    tick(4);
    trig = 1'b1;
    push_dump();
    @(negedge clk);
    chk("trig_pre_valid", 64'(valid), 64'd0);
    @(posedge clk);
    #1;
    trig = 1'b0;
    @(negedge clk);
    chk("trig_valid", 64'(valid), 64'd1);
    chk("trig_cnt", 64'(cnt), 64'd5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(valid && idx == 7) && n < 40);
    chk("reach_idx7", 64'(idx), 64'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midreset");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_dump();
    wait_valid(40);
    chk("rerun_cnt", 64'(cnt), 64'd24);
    wait_idle(40);
    chk("rerun_done", 64'(done), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
